quad_step_decoder: RTL and testbench

Upstream stage for the 4-bit up/down counter: decodes a two-channel quadrature encoder (A/B) into a direction bit and a one-cycle count pulse. Both raw channels are asynchronous to `clk`. The block synchronises and glitch-filters them, tracks the Gray-coded phase, and emits `step` plus `upordown`, which drive the counter's enable and direction inputs. Illegal phase jumps are flagged, not counted.

---
 rtl/quad_pkg.sv | 36 +++
 rtl/quad_chan_filter.sv | 74 +++++++
 rtl/quad_step_decoder.sv | 111 +++++++++++
 tb/tb_quad_step_decoder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// -----------------------------------------------------------------------------
// quad_pkg
// Shared types and helpers for the quadrature step decoder.
//   state_e        : decoder FSM states (INIT, TRACK)
//   PH_xx          : Gray-coded phase constants, phase = {a, b}
//   CNT_W          : width of the per-channel filter counters (FILTER_LEN <= 15)
//   next_up_phase  : phase that follows the argument when rotating "up"
// -----------------------------------------------------------------------------
package quad_pkg;

    localparam int CNT_W = 4;

    typedef enum logic {
        INIT  = 1'b0,
        TRACK = 1'b1
    } state_e;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    // Up order is 00 -> 10 -> 11 -> 01 -> 00 (channel A leads B).
    function automatic logic [1:0] next_up_phase(input logic [1:0] phase);
        logic [1:0] nxt;
        nxt = PH_00;
        case (phase)
            PH_00:   nxt = PH_10;
            PH_10:   nxt = PH_11;
            PH_11:   nxt = PH_01;
            default: nxt = PH_00;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/quad_chan_filter.sv
// -----------------------------------------------------------------------------
// quad_chan_filter
// One encoder channel: 2-FF synchroniser followed by a glitch filter.
// The filtered level only follows the synchronised level after FILTER_LEN
// consecutive differing samples; shorter pulses are dropped.
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset
//   raw_i    : raw asynchronous channel input
//   filt_o   : filtered channel level
//   stable_o : high once FILTER_LEN consecutive samples matched filt_o
// -----------------------------------------------------------------------------
module quad_chan_filter
    import quad_pkg::*;
#(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic filt_o,
    output logic stable_o
);

    localparam logic [CNT_W-1:0] LEN    = CNT_W'(FILTER_LEN);
    localparam logic [CNT_W-1:0] LEN_M1 = CNT_W'(FILTER_LEN - 1);

    logic [1:0]       sync_q;
    logic [1:0]       fill_q;
    logic [CNT_W-1:0] diff_cnt_q, diff_cnt_d;
    logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
    logic             filt_q, filt_d;
    logic             sample;

    assign sample = sync_q[1];

    always_comb begin
        diff_cnt_d = '0;
        stab_cnt_d = stab_cnt_q;
        filt_d     = filt_q;
        if (sample != filt_q) begin
            stab_cnt_d = '0;
            if (diff_cnt_q == LEN_M1) begin
                filt_d = sample;
            end else begin
                diff_cnt_d = diff_cnt_q + 1'b1;
            end
        end else if (fill_q[1] && (stab_cnt_q != LEN)) begin
            // Stability is only counted once the synchroniser holds real
            // samples, so INIT cannot complete on reset-value contents.
            stab_cnt_d = stab_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q     <= 2'b00;
            fill_q     <= 2'b00;
            diff_cnt_q <= '0;
            stab_cnt_q <= '0;
            filt_q     <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], raw_i};
            fill_q     <= {fill_q[0], 1'b1};
            diff_cnt_q <= diff_cnt_d;
            stab_cnt_q <= stab_cnt_d;
            filt_q     <= filt_d;
        end
    end

    assign filt_o   = filt_q;
    assign stable_o = (stab_cnt_q == LEN);

endmodule

// File: rtl/quad_step_decoder.sv
// -----------------------------------------------------------------------------
// quad_step_decoder
// Decodes a two-channel quadrature encoder into a one-cycle step pulse and a
// direction bit (x4 decoding). Illegal two-bit phase jumps set a sticky error.
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset
//   enc_a    : raw encoder channel A (asynchronous)
//   enc_b    : raw encoder channel B (asynchronous)
//   err_clr  : synchronous clear of error (a coincident new error wins)
//   step     : one-cycle pulse per valid phase transition
//   upordown : direction of last valid step, 1 = up, 0 = down
//   error    : sticky illegal-transition flag
// -----------------------------------------------------------------------------
module quad_step_decoder
    import quad_pkg::*;
#(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic enc_a,
    input  logic enc_b,
    input  logic err_clr,
    output logic step,
    output logic upordown,
    output logic error
);

    logic       a_f, b_f;
    logic       a_stable, b_stable;
    logic [1:0] phase;

    state_e     state_q, state_d;
    logic [1:0] prev_phase_q, prev_phase_d;
    logic       step_q, step_d;
    logic       dir_q, dir_d;
    logic       err_q, err_d;

    quad_chan_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
        .clk      (clk),
        .reset    (reset),
        .raw_i    (enc_a),
        .filt_o   (a_f),
        .stable_o (a_stable)
    );

    quad_chan_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
        .clk      (clk),
        .reset    (reset),
        .raw_i    (enc_b),
        .filt_o   (b_f),
        .stable_o (b_stable)
    );

    assign phase = {a_f, b_f};

    always_comb begin
        state_d      = state_q;
        prev_phase_d = prev_phase_q;
        step_d       = 1'b0;
        dir_d        = dir_q;
        // Clear first so that an error detected below overrides it.
        err_d        = err_q & ~err_clr;
        case (state_q)
            INIT: begin
                if (a_stable && b_stable) begin
                    prev_phase_d = phase;
                    state_d      = TRACK;
                end
            end
            TRACK: begin
                if (phase != prev_phase_q) begin
                    prev_phase_d = phase;
                    if (next_up_phase(prev_phase_q) == phase) begin
                        step_d = 1'b1;
                        dir_d  = 1'b1;
                    end else if (next_up_phase(phase) == prev_phase_q) begin
                        step_d = 1'b1;
                        dir_d  = 1'b0;
                    end else begin
                        // Both bits moved at once: position is ambiguous.
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= INIT;
            prev_phase_q <= PH_00;
            step_q       <= 1'b0;
            dir_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_phase_q <= prev_phase_d;
            step_q       <= step_d;
            dir_q        <= dir_d;
            err_q        <= err_d;
        end
    end

    assign step     = step_q;
    assign upordown = dir_q;
    assign error    = err_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
module tb_quad_step_decoder;

    localparam int N   = 3;
    localparam int LAT = N + 3;

    logic clk, reset, enc_a, enc_b, err_clr;
    logic step, upordown, error;

    quad_step_decoder #(.FILTER_LEN(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .enc_a    (enc_a),
        .enc_b    (enc_b),
        .err_clr  (err_clr),
        .step     (step),
        .upordown (upordown),
        .error    (error)
    );

    typedef struct {
        int   cyc;
        logic dir;
    } exp_t;

    exp_t       sb[$];
    exp_t       got;
    int         cyc        = 0;
    int         errors     = 0;
    int         checks     = 0;
    int         steps_seen = 0;
    logic [1:0] cur_ph;
    logic [1:0] up_seq [4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard consumer: every step pulse must match the next queued entry.
    always @(negedge clk) begin
        if (reset === 1'b1 && step === 1'b1) begin
            steps_seen++;
            if (sb.size() == 0) begin
                check("unexpected_step_queue_size", 32'(sb.size()), 32'd1);
            end else begin
                got = sb.pop_front();
                check("step_cycle", 32'(cyc), 32'(got.cyc));
                check("step_dir", 32'(upordown), 32'(got.dir));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a new raw phase; when push is set, queue the step the model predicts.
    task automatic drive(input logic [1:0] ph, input bit push);
        int   idx;
        exp_t e;
        @(negedge clk);
        enc_a = ph[1];
        enc_b = ph[0];
        idx = 0;
        for (int i = 0; i < 4; i++) if (up_seq[i] == cur_ph) idx = i;
        if (push && up_seq[(idx + 1) % 4] == ph) begin
            e.cyc = cyc + LAT; e.dir = 1'b1; sb.push_back(e);
        end else if (push && up_seq[(idx + 3) % 4] == ph) begin
            e.cyc = cyc + LAT; e.dir = 1'b0; sb.push_back(e);
        end
        cur_ph = ph;
    endtask

    initial begin
        reset   = 1'b0;
        enc_a   = 1'b0;
        enc_b   = 1'b0;
        err_clr = 1'b0;
        cur_ph  = 2'b00;
        up_seq  = '{2'b00, 2'b10, 2'b11, 2'b01};

        // Reset held low
        #20;
        check("rst_step", 32'(step), 32'd0);
        check("rst_dir", 32'(upordown), 32'd0);
        check("rst_err", 32'(error), 32'd0);
        #30;
        @(negedge clk);
        reset = 1'b1;
        repeat (N + 2) begin
            @(negedge clk);
            check("init_step", 32'(step), 32'd0);
            check("init_err", 32'(error), 32'd0);
        end
        tick(6);

        // Forward rotation
        drive(2'b10, 1); tick(11);
        drive(2'b11, 1); tick(11);
        drive(2'b01, 1); tick(11);
        drive(2'b00, 1); tick(11);
        check("fwd_pending", 32'(sb.size()), 32'd0);
        check("fwd_steps", 32'(steps_seen), 32'd4);
        check("fwd_dir", 32'(upordown), 32'd1);

        // Reverse rotation
        drive(2'b01, 1); tick(11);
        drive(2'b11, 1); tick(11);
        drive(2'b10, 1); tick(11);
        drive(2'b00, 1); tick(11);
        check("rev_pending", 32'(sb.size()), 32'd0);
        check("rev_steps", 32'(steps_seen), 32'd8);
        check("rev_dir", 32'(upordown), 32'd0);

        // Single forward step flips direction with its pulse
        drive(2'b10, 1); tick(11);
        check("flip_steps", 32'(steps_seen), 32'd9);
        check("flip_dir", 32'(upordown), 32'd1);
        drive(2'b00, 1); tick(11);

        // Glitch on A shorter than the filter length
        @(negedge clk); enc_a = 1'b1;
        @(negedge clk);
        @(negedge clk); enc_a = 1'b0;
        tick(12);
        check("glitch_steps", 32'(steps_seen), 32'd10);
        check("glitch_err", 32'(error), 32'd0);
        // A real up step proves the tracked phase stayed at 00
        drive(2'b10, 1); tick(11);
        drive(2'b00, 1); tick(11);
        check("post_glitch_pending", 32'(sb.size()), 32'd0);
        check("post_glitch_steps", 32'(steps_seen), 32'd12);

        // Illegal jump 00 -> 11
        drive(2'b11, 1); tick(LAT + 2);
        check("illegal_err", 32'(error), 32'd1);
        check("illegal_dir", 32'(upordown), 32'd0);
        check("illegal_steps", 32'(steps_seen), 32'd12);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        check("err_cleared", 32'(error), 32'd0);

        // Illegal jump 11 -> 00 coincident with err_clr
        drive(2'b00, 1); tick(LAT - 1);
        check("pre_coinc_err", 32'(error), 32'd0);
        err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        check("coinc_err_set_wins", 32'(error), 32'd1);
        tick(3);
        check("coinc_err_sticky", 32'(error), 32'd1);
        check("coinc_steps", 32'(steps_seen), 32'd12);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        check("err_cleared2", 32'(error), 32'd0);

        // Reset while step is high
        drive(2'b10, 0);
        repeat (LAT) @(posedge clk);
        #1;
        check("mid_step_hi", 32'(step), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_step", 32'(step), 32'd0);
        check("mid_rst_dir", 32'(upordown), 32'd0);
        check("mid_rst_err", 32'(error), 32'd0);
        @(negedge clk);
        enc_a  = 1'b1;
        enc_b  = 1'b1;
        cur_ph = 2'b11;
        tick(3);
        @(negedge clk); reset = 1'b1;
        tick(2 * LAT + 6);
        check("rerun_err", 32'(error), 32'd0);
        check("rerun_steps", 32'(steps_seen), 32'd12);
        drive(2'b01, 1); tick(11);
        check("rerun_pending", 32'(sb.size()), 32'd0);
        check("rerun_step_count", 32'(steps_seen), 32'd13);
        check("rerun_dir", 32'(upordown), 32'd1);
        check("final_err", 32'(error), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
